dense_neuron_par: RTL and testbench
===================================

Name: dense_neuron_par

Overview:
Next-generation single dense-layer neuron: a parallel-lane multiply-accumulate over an IN_NEUR-element input vector. It adds a fractional-aligned bias, rounds, saturates and optionally applies ReLU, producing a fixed-point result. It sits in the classifier layer, one instance per output neuron. The layer controller drives it with a start/busy request and a valid/ready result handshake.

Parameters:
DATA_W, 16, signed width of inputs, weights, bias and output (two's complement).
FRAC_W, 8, fractional bits of all fixed-point operands; legal range 1..DATA_W-1.
IN_NEUR, 121, number of input elements.
LANES, 4, multipliers used per cycle; legal range 1..IN_NEUR.
ACC_W, 48, accumulator width; must be >= 2*DATA_W + clog2(IN_NEUR).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request a computation; accepted only in IDLE.
relu_en  in  1  ReLU enable; sampled when start is accepted.
in_vec  in  DATA_W x IN_NEUR  signed activations; must be held stable from start until out_valid.
weights  in  DATA_W x IN_NEUR  signed weights; same stability rule.
bias  in  DATA_W  signed bias in the same Q format as the inputs; same stability rule.
busy  out  1  high whenever state != IDLE.
out_val  out  DATA_W  signed result.
out_valid  out  1  result valid; held until out_ready.
out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; acc, beat counter, relu_q, out_val, out_valid all 0; busy=0.
- BEATS = ceil(IN_NEUR/LANES). States: IDLE, MAC, FINISH, OUT.
- IDLE: when start=1, clear acc and beat counter, latch relu_q<=relu_en, go to MAC. When start=0, stay.
- MAC, beat k = 0..BEATS-1, one beat per cycle:
  - Lane j uses index i = k*LANES + j.
  - product = in_vec[i]*weights[i], full 2*DATA_W signed, sign-extended to ACC_W.
  - Lanes with i >= IN_NEUR contribute 0 and must not index out of range.
  - acc <= acc + sum of all lane products; the lane sum is a combinational adder tree.
  - After beat BEATS-1, go to FINISH.
- FINISH, one cycle:
  - t = acc + (sign-extended bias << FRAC_W) + (1 << (FRAC_W-1)). This is round half up.
  - s = t >>> FRAC_W (arithmetic shift).
  - Saturate s to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - If relu_q=1 and the result is negative, force 0.
  - out_val <= result; out_valid <= 1; go to OUT.
- OUT: hold out_val and out_valid stable. When out_ready=1, clear out_valid and go to IDLE on the next edge.
  - out_ready already high on the cycle out_valid rises → handshake completes that cycle.
  - out_val retains its last value after the handshake.
- Latency: start accepted at edge E0 → out_valid high after edge E(BEATS+1).
  - Minimum start-to-start spacing is BEATS+3 cycles.
  - A start asserted in the same cycle as the OUT handshake is ignored; state is still OUT at that edge.
- start while busy=1: ignored, with no effect on the computation or on relu_q.
- Accumulator never wraps within the legal ACC_W bound. Saturation is applied only at the output.
- rst_n asserted mid-MAC or mid-OUT: immediate abort, all outputs 0. The next start behaves as from fresh reset.
- Multipliers are DSP-mapped, LANES instances total.

Test Plan:
1. Config DATA_W=16, FRAC_W=8, IN_NEUR=5, LANES=2 (BEATS=3), used for all scenarios. Stimulus: all in=256 (1.0), all w=128 (0.5), bias=64 (0.25), relu_en=0, start pulse → out_val=704 (0x02C0). out_valid rises exactly 4 edges after the start edge; busy high for that whole window. This also checks the masked lane 1 of beat 2.
2. Saturation: all in=w=0x7FFF, bias=0x7FFF → out_val=0x7FFF. Then in=0x7FFF, w=0x8000 → out_val=0x8000.
3. ReLU and negative rounding: all in=256, w=-128 (0xFF80), bias=0.
   - relu_en=0 → out_val=-640 (0xFD80).
   - relu_en=1 → out_val=0.
   - relu_en toggled mid-MAC → result unchanged.
4. Rounding boundary: in[0]=1, w[0]=128, all others 0, bias=0 → out_val=1. With w[0]=127 → out_val=0.
5. Backpressure: out_ready=0 for 5 cycles after out_valid, with start pulsed during the hold → out_val, out_valid stable and busy=1. Raise out_ready=1 → out_valid=0 and busy=0 next edge; a subsequent start yields the correct result.
6. Reset mid-operation: assert rst_n low at MAC beat 1 → busy, out_valid, out_val go 0 immediately. Release and rerun scenario 1 → 704 with the same latency.

Source files
------------

// File: rtl/dense_neuron_par_if.sv
// Request/result bus between the layer controller (master) and one dense neuron (slave).
// Activations, weights and bias are held stable by the master from start until out_valid.
interface dense_neuron_par_if #(
    parameter int DATA_W  = 16,
    parameter int IN_NEUR = 121
);
    logic                             start;
    logic                             relu_en;
    logic [IN_NEUR-1:0][DATA_W-1:0]   in_vec;
    logic [IN_NEUR-1:0][DATA_W-1:0]   weights;
    logic [DATA_W-1:0]                bias;
    logic                             busy;
    logic [DATA_W-1:0]                out_val;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output start, relu_en, in_vec, weights, bias, out_ready,
        input  busy, out_val, out_valid
    );

    modport slave (
        input  start, relu_en, in_vec, weights, bias, out_ready,
        output busy, out_val, out_valid
    );
endinterface

// File: rtl/dense_neuron_par.sv
// Dense-layer neuron: LANES-wide MAC over IN_NEUR inputs, then bias add, round-half-up,
// saturation and optional ReLU into a DATA_W fixed-point result.
//
// state  | meaning
// IDLE   | waiting for start; accumulator cleared on acceptance
// MAC    | one beat per cycle, LANES products summed into acc
// FINISH | bias, rounding, saturation, ReLU; result registered
// OUT    | result held until out_ready
module dense_neuron_par #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IN_NEUR = 121,
    parameter int LANES   = 4,
    parameter int ACC_W   = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    dense_neuron_par_if.slave  bus
);
    localparam int BEATS = (IN_NEUR + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = $clog2(BEATS * LANES + 1);
    localparam int SEL_W = (IN_NEUR > 1) ? $clog2(IN_NEUR) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ROUND   = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        FINISH = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          beat_q, beat_d;
    logic                      relu_q, relu_d;
    logic [DATA_W-1:0]         out_val_q, out_val_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]   lane_sum;
    logic signed [PROD_W-1:0]  prod;
    logic [IDX_W-1:0]          idx;
    logic [SEL_W-1:0]          sel;

    // Lane adder tree; lanes past the last element are gated off and their index is clamped.
    always_comb begin
        lane_sum = '0;
        prod     = '0;
        idx      = '0;
        sel      = '0;
        for (int j = 0; j < LANES; j++) begin
            idx = IDX_W'(beat_q) * IDX_W'(LANES) + IDX_W'(j);
            if (idx < IDX_W'(IN_NEUR)) begin
                sel  = idx[SEL_W-1:0];
                prod = $signed(bus.in_vec[sel]) * $signed(bus.weights[sel]);
                lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
    end

    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   rnd_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [DATA_W-1:0]         sat_val;
    logic [DATA_W-1:0]         final_val;

    always_comb begin
        bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
        rnd_sum  = acc_q + (bias_ext <<< FRAC_W) + ROUND;
        shifted  = rnd_sum >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
        final_val = (relu_q && sat_val[DATA_W-1]) ? '0 : sat_val;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        relu_d      = relu_q;
        out_val_d   = out_val_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    beat_d  = '0;
                    relu_d  = bus.relu_en;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + lane_sum;
                if (beat_q == CNT_W'(BEATS - 1)) begin
                    state_d = FINISH;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            FINISH: begin
                out_val_d   = final_val;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            relu_q      <= 1'b0;
            out_val_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            relu_q      <= relu_d;
            out_val_q   <= out_val_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_val   = out_val_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_dense_neuron_par.sv
// Directed bench for dense_neuron_par with IN_NEUR=5, LANES=2 (three MAC beats).
module tb_dense_neuron_par;
    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int IN_NEUR = 5;
    localparam int LANES   = 2;
    localparam int ACC_W   = 48;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    dense_neuron_par_if #(.DATA_W(DATA_W), .IN_NEUR(IN_NEUR)) bus ();

    dense_neuron_par #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .IN_NEUR(IN_NEUR), .LANES(LANES), .ACC_W(ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [15:0] in_v, input logic [15:0] w_v, input logic [15:0] b_v);
        for (int i = 0; i < IN_NEUR; i++) begin
            bus.in_vec[i]  = in_v;
            bus.weights[i] = w_v;
        end
        bus.bias = b_v;
    endtask

    // Pulse start, then count edges until out_valid rises (bounded).
    task automatic run(input logic relu, input bit toggle, output logic [15:0] val,
                       output int lat, output bit busy_ok);
        bus.relu_en = relu;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (toggle && lat == 1) bus.relu_en = ~relu;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        val = bus.out_val;
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.relu_en   = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic do_vec(input string tag, input logic relu, input bit toggle, input logic [15:0] exp);
        logic [15:0] val;
        int          lat;
        bit          busy_ok;
        run(relu, toggle, val, lat, busy_ok);
        check({tag, "_val"}, {16'd0, val}, {16'd0, exp});
        check({tag, "_lat"}, lat, 32'd4);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        accept(tag);
    endtask

    initial begin
        logic [15:0] val;
        int          lat;
        bit          busy_ok;
        bit          stable;

        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.start     = 1'b0;
        bus.relu_en   = 1'b0;
        bus.out_ready = 1'b0;
        set_data(16'd0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_val",   {16'd0, bus.out_val}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 * 0.5 * 5 + 0.25 = 2.75 -> 704
        set_data(16'd256, 16'd128, 16'd64);
        do_vec("basic", 1'b0, 1'b0, 16'h02C0);

        set_data(16'h7FFF, 16'h7FFF, 16'h7FFF);
        do_vec("sat_pos", 1'b0, 1'b0, 16'h7FFF);
        set_data(16'h7FFF, 16'h8000, 16'h7FFF);
        do_vec("sat_neg", 1'b0, 1'b0, 16'h8000);

        // -2.5 + half rounds toward +inf: -639.5 -> -640
        set_data(16'd256, 16'hFF80, 16'd0);
        do_vec("neg_round", 1'b0, 1'b0, 16'hFD80);
        do_vec("relu_on",   1'b1, 1'b0, 16'h0000);
        do_vec("relu_tog",  1'b0, 1'b1, 16'hFD80);

        set_data(16'd0, 16'd0, 16'd0);
        bus.in_vec[0]  = 16'd1;
        bus.weights[0] = 16'd128;
        do_vec("round_up", 1'b0, 1'b0, 16'h0001);
        bus.weights[0] = 16'd127;
        do_vec("round_dn", 1'b0, 1'b0, 16'h0000);

        // Backpressure with a start pulse while held in OUT
        set_data(16'd256, 16'd128, 16'd64);
        run(1'b0, 1'b0, val, lat, busy_ok);
        check("bp_val", {16'd0, val}, 32'h02C0);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.start   = 1'b1;
                bus.relu_en = 1'b1;
            end
            if (c == 2) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.out_val !== 16'h02C0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) stable = 1'b0;
        end
        bus.relu_en = 1'b0;
        check("bp_stable", {31'd0, stable}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_valid_clr", {31'd0, bus.out_valid}, 32'd0);
        check("bp_busy_clr",  {31'd0, bus.busy}, 32'd0);
        check("bp_val_hold",  {16'd0, bus.out_val}, 32'h02C0);
        set_data(16'd256, 16'hFF80, 16'd0);
        do_vec("bp_next", 1'b0, 1'b0, 16'hFD80);

        // Reset during MAC beat 1 after a completed result is on out_val
        set_data(16'd256, 16'd128, 16'd64);
        do_vec("pre_rst", 1'b0, 1'b0, 16'h02C0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy",  {31'd0, bus.busy}, 32'd0);
        check("mid_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_val",   {16'd0, bus.out_val}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_vec("post_rst", 1'b0, 1'b0, 16'h02C0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
